moore_sequencer: RTL and testbench
==================================

MOORE_SEQUENCER -- requirements
Module: moore_sequencer

Interface
REQ-001 The block SHALL have parameters, one per line:
- TICK_WIDTH, 20, width of the tick prescaler counter.
- TICK_MAX, 599999, prescaler terminal count; one tick every TICK_MAX+1 clk cycles.
- DEB_COUNT, 4, consecutive ticks goInput must hold a new level before it is accepted (1..255).
- PROC_STEPS, 3, ticks spent in PROC per run (1..255).
- LED_WIDTH, 4, width of the led counter.
REQ-002 The block SHALL have ports, one per line:
- clk  in  1  system clock (12 MHz).
- rstInput  in  1  reset; asynchronous, active-high.
- goInput  in  1  start request; asynchronous to clk, may bounce.
- abortInput  in  1  abort request; asynchronous to clk.
- led  out  LED_WIDTH  run-step counter.
- doneSig  out  1  high while in DONE.
- busySig  out  1  high while in PROC.
- stateOut  out  2  current state encoding.
- tickOut  out  1  one-clk prescaler tick pulse.

Function
REQ-003 All registers SHALL be clocked by clk only; no derived clocks; tick is a clock enable.
REQ-004 Prescaler: counter 0..TICK_MAX; tickOut=1 for exactly the clk cycle in which the counter equals TICK_MAX, which wraps it to 0.
REQ-005 goInput and abortInput SHALL each pass through a two-flop synchroniser (goSync, abortSync) before any use.
REQ-006 Debounce: the debounce counter updates only on ticks; if goSync differs from goDeb, it increments, else it clears to 0.
REQ-007 When goSync differs from goDeb on the tick where the counter equals DEB_COUNT-1, goDeb SHALL toggle and the counter clear on that same tick.
REQ-008 State encoding: IDLE=0, PROC=1, DONE=2, ABORT=3; stateOut SHALL equal the state register.
REQ-009 State transitions SHALL be evaluated only on ticks, using register values from before that tick's updates.
REQ-010 IDLE: goDeb=1 -> PROC with step counter cleared to 0; else stay.
REQ-011 PROC, abortSync=1: -> ABORT; led SHALL NOT increment on that tick (abort has priority).
REQ-012 PROC, abortSync=0: led <= led+1 modulo 2^LED_WIDTH, step counter +1.
REQ-013 PROC, abortSync=0, step counter = PROC_STEPS-1: -> DONE on that same tick, so led advances exactly PROC_STEPS per completed run.
REQ-014 DONE: goDeb=0 -> IDLE; else stay, so go held high SHALL NOT retrigger a run.
REQ-015 ABORT: goDeb=0 -> IDLE; else stay.
REQ-016 abortSync in IDLE, DONE or ABORT SHALL have no effect.
REQ-017 led SHALL keep its value across runs and wrap from all-ones to 0; only reset clears it.
REQ-018 doneSig=(state==DONE) and busySig=(state==PROC), decoded combinationally from the state register (Moore; no input dependence).
REQ-019 Illegal state values are unreachable with 2-bit encoding; any default case SHALL go to IDLE.

Reset
REQ-020 rstInput=1 SHALL asynchronously force: prescaler, debounce counter, step counter, synchronisers, goDeb to 0; state IDLE; led=0; tickOut=0; doneSig=0; busySig=0; stateOut=0.
REQ-021 Reset asserted mid-run (any state) SHALL abort immediately with the values of REQ-020.
REQ-022 After deassertion, the first tick SHALL occur TICK_MAX+1 clk cycles later.

Verification (TICK_MAX=3, DEB_COUNT=2, PROC_STEPS=3, LED_WIDTH=4)
REQ-023 Clean run: goInput held 1 -> goDeb rises after 2 ticks, PROC on next tick, busySig 3 ticks, led 0->3, doneSig=1; goInput 0 -> IDLE after 2 debounce ticks plus one.
REQ-024 Bounce: goInput toggles every 3 clk for 40 clk, then 0 -> goDeb stays 0, state stays IDLE, led=0.
REQ-025 Abort: abortInput=1 during second PROC tick -> state ABORT, led=1, doneSig=0; release go -> IDLE.
REQ-026 Wrap: 6 complete runs -> led=18 mod 16 = 2.
REQ-027 Reset mid-PROC: rstInput pulse with led=1 -> all outputs 0 within the same cycle, no clk edge required.
REQ-028 Prescaler: tickOut high exactly 1 clk of every 4, never 2 consecutive cycles.

Source files
------------

// File: rtl/moore_sequencer.sv
// moore_sequencer: tick-paced Moore sequencer.
// A prescaler produces a one-clk tick enable. A debounced start request
// launches a run of PROC_STEPS ticks that advances a persistent led counter.
// A synchronised abort request cuts a run short. Going back to IDLE from
// DONE or ABORT needs the start request to be released first.
module moore_sequencer #(
    parameter int TICK_WIDTH = 20,
    parameter int TICK_MAX   = 599999,
    parameter int DEB_COUNT  = 4,
    parameter int PROC_STEPS = 3,
    parameter int LED_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rstInput,
    input  logic                 goInput,
    input  logic                 abortInput,
    output logic [LED_WIDTH-1:0] led,
    output logic                 doneSig,
    output logic                 busySig,
    output logic [1:0]           stateOut,
    output logic                 tickOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROC  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // Terminal values cast once to the width of the registers they compare against.
    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_MAX);
    localparam logic [7:0]            DEB_LAST  = 8'(DEB_COUNT - 1);
    localparam logic [7:0]            STEP_LAST = 8'(PROC_STEPS - 1);

    localparam int SYNC_CHANNELS = 2;

    logic [TICK_WIDTH-1:0]    presc_reg;
    logic                     tick;

    logic [SYNC_CHANNELS-1:0] async_in;
    logic [SYNC_CHANNELS-1:0] sync_meta_reg;
    logic [SYNC_CHANNELS-1:0] sync_reg;
    logic                     go_sync;
    logic                     abort_sync;

    logic [7:0]               deb_cnt_reg;
    logic                     go_deb_reg;

    state_t                   state_reg;
    logic [7:0]               step_reg;
    logic [LED_WIDTH-1:0]     led_reg;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------

    // The tick is a clock enable, high for the single cycle spent at the
    // terminal count.
    assign tick = (presc_reg == TICK_LAST);

    // Free-running prescaler counting 0..TICK_MAX and wrapping on the tick.
    always_ff @(posedge clk or posedge rstInput) begin
        if (rstInput) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + TICK_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisers (bit 0 = go, bit 1 = abort)
    // ------------------------------------------------------------------

    assign async_in = {abortInput, goInput};

    generate
        for (genvar gi = 0; gi < SYNC_CHANNELS; gi++) begin : g_sync
            // Two-flop synchroniser; nothing downstream sees the raw pin.
            always_ff @(posedge clk or posedge rstInput) begin
                if (rstInput) begin
                    sync_meta_reg[gi] <= 1'b0;
                    sync_reg[gi]      <= 1'b0;
                end else begin
                    sync_meta_reg[gi] <= async_in[gi];
                    sync_reg[gi]      <= sync_meta_reg[gi];
                end
            end
        end
    endgenerate

    assign go_sync    = sync_reg[0];
    assign abort_sync = sync_reg[1];

    // ------------------------------------------------------------------
    // Debounce of the start request
    // ------------------------------------------------------------------

    // A new level is accepted only after it has been seen on DEB_COUNT
    // consecutive ticks. Any tick where it matches the accepted level
    // restarts the count.
    always_ff @(posedge clk or posedge rstInput) begin
        if (rstInput) begin
            deb_cnt_reg <= '0;
            go_deb_reg  <= 1'b0;
        end else if (tick) begin
            if (go_sync != go_deb_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    go_deb_reg  <= go_sync;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 8'd1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // State, step counter and led advance together on ticks. Decisions use
    // go_deb_reg/abort_sync as they were before this tick's debounce update.
    always_ff @(posedge clk or posedge rstInput) begin
        if (rstInput) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            led_reg   <= '0;
        end else if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (go_deb_reg) begin
                        state_reg <= PROC;
                        step_reg  <= '0;
                    end
                end
                PROC: begin
                    // Abort wins over the step: led is left untouched.
                    if (abort_sync) begin
                        state_reg <= ABORT;
                    end else begin
                        led_reg <= led_reg + LED_WIDTH'(1);
                        if (step_reg == STEP_LAST) begin
                            state_reg <= DONE;
                            step_reg  <= '0;
                        end else begin
                            step_reg <= step_reg + 8'd1;
                        end
                    end
                end
                DONE: begin
                    // Holding go keeps us here so a run is not retriggered.
                    if (!go_deb_reg) begin
                        state_reg <= IDLE;
                    end
                end
                ABORT: begin
                    if (!go_deb_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs, decoded from registers only
    // ------------------------------------------------------------------

    assign led      = led_reg;
    assign stateOut = state_reg;
    assign doneSig  = (state_reg == DONE);
    assign busySig  = (state_reg == PROC);
    assign tickOut  = tick;

endmodule

// File: tb/tb_moore_sequencer.sv
// tb_moore_sequencer: directed self-checking bench for moore_sequencer
// with a 4-clk tick, 2-tick debounce and 3-step runs.
`timescale 1ns/1ps
module tb_moore_sequencer;

    logic       clk = 1'b0;
    logic       rstInput = 1'b1;
    logic       goInput = 1'b0;
    logic       abortInput = 1'b0;
    logic [3:0] led;
    logic       doneSig;
    logic       busySig;
    logic [1:0] stateOut;
    logic       tickOut;

    int tests_run = 0;
    int tests_failed = 0;

    moore_sequencer #(
        .TICK_WIDTH(4),
        .TICK_MAX  (3),
        .DEB_COUNT (2),
        .PROC_STEPS(3),
        .LED_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rstInput  (rstInput),
        .goInput   (goInput),
        .abortInput(abortInput),
        .led       (led),
        .doneSig   (doneSig),
        .busySig   (busySig),
        .stateOut  (stateOut),
        .tickOut   (tickOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Returns 1ns after the next clk edge on which a tick takes effect.
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (tickOut !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        assert (n < 16) else begin
            tests_failed++;
            $error("FAIL tick_timeout observed=%0d expected=<16", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int count);
        for (int i = 0; i < count; i++) wait_tick();
    endtask

    // Synchronous-looking reset pulse released 1ns after a clk edge.
    task automatic do_reset();
        rstInput   = 1'b1;
        goInput    = 1'b0;
        abortInput = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstInput = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"},   led,      0);
        check({tag, "_state"}, stateOut, 0);
        check({tag, "_done"},  doneSig,  0);
        check({tag, "_busy"},  busySig,  0);
        check({tag, "_tick"},  tickOut,  0);
    endtask

    initial begin
        int highs;
        int doubles;
        logic prev;

        // ---- Reset values ----
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // ---- Prescaler: first tick 4 clk after release, then 1 in 4 ----
        rstInput = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("presc_pre_first", tickOut, 0);
        @(posedge clk);
        #1;
        check("presc_first", tickOut, 1);
        highs = 0;
        doubles = 0;
        prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tickOut) highs++;
            if (tickOut && prev) doubles++;
            prev = tickOut;
            @(posedge clk);
            #1;
        end
        check("presc_highs_16", highs, 4);
        check("presc_doubles", doubles, 0);

        // ---- Bounce: go toggles every 3 clk, never stable for 2 ticks ----
        wait_tick();
        goInput = 1'b1;
        for (int i = 0; i < 13; i++) begin
            repeat (3) @(posedge clk);
            #1;
            goInput = ~goInput;
        end
        goInput = 1'b0;
        wait_ticks(4);
        check("bounce_state", stateOut, 0);
        check("bounce_led", led, 0);

        // ---- Clean run ----
        goInput = 1'b1;
        wait_ticks(2);
        check("clean_t2_state", stateOut, 0);
        wait_tick();
        check("clean_t3_state", stateOut, 1);
        check("clean_t3_busy", busySig, 1);
        check("clean_t3_led", led, 0);
        wait_ticks(2);
        check("clean_t5_led", led, 2);
        check("clean_t5_busy", busySig, 1);
        wait_tick();
        check("clean_t6_state", stateOut, 2);
        check("clean_t6_done", doneSig, 1);
        check("clean_t6_busy", busySig, 0);
        check("clean_t6_led", led, 3);
        // Abort while DONE, go still held: nothing changes.
        abortInput = 1'b1;
        wait_tick();
        check("clean_hold_state", stateOut, 2);
        check("clean_hold_led", led, 3);
        abortInput = 1'b0;
        goInput = 1'b0;
        wait_ticks(2);
        check("clean_rel_t2_state", stateOut, 2);
        wait_tick();
        check("clean_rel_t3_state", stateOut, 0);
        check("clean_rel_done", doneSig, 0);

        // ---- Abort on the second PROC tick ----
        do_reset();
        wait_tick();
        goInput = 1'b1;
        wait_ticks(4);
        check("abort_t4_state", stateOut, 1);
        check("abort_t4_led", led, 1);
        abortInput = 1'b1;
        wait_tick();
        check("abort_state", stateOut, 3);
        check("abort_led", led, 1);
        check("abort_done", doneSig, 0);
        check("abort_busy", busySig, 0);
        abortInput = 1'b0;
        wait_tick();
        check("abort_hold_state", stateOut, 3);
        goInput = 1'b0;
        wait_ticks(2);
        check("abort_rel_t2_state", stateOut, 3);
        wait_tick();
        check("abort_rel_t3_state", stateOut, 0);
        check("abort_rel_led", led, 1);

        // ---- Wrap: six complete runs from led=0 ----
        do_reset();
        wait_tick();
        for (int r = 0; r < 6; r++) begin
            goInput = 1'b1;
            wait_ticks(6);
            check($sformatf("wrap_run%0d_state", r), stateOut, 2);
            check($sformatf("wrap_run%0d_led", r), led, (3 * (r + 1)) % 16);
            goInput = 1'b0;
            wait_ticks(3);
            check($sformatf("wrap_run%0d_idle", r), stateOut, 0);
        end
        check("wrap_final_led", led, 2);

        // ---- Reset asserted mid-PROC clears outputs without a clk edge ----
        do_reset();
        wait_tick();
        goInput = 1'b1;
        wait_ticks(4);
        check("midrst_pre_state", stateOut, 1);
        check("midrst_pre_led", led, 1);
        #2;
        rstInput = 1'b1;
        #1;
        check_all_zero("midrst");
        goInput = 1'b0;
        @(posedge clk);
        #1;
        rstInput = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
